// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results and queued load responses
// onto the register file's single write port, and tracks pending loads.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data   ALU result (no backpressure, highest priority)
//   ld_valid/ld_ready           load response handshake (ready = queue not full)
//   ld_rd/ld_data/ld_funct3/ld_off  load destination, raw word, type, byte offset
//   iss_valid/iss_rd            load issue from decode (sets pending bit)
//   q1_addr/q1_busy, q2_addr/q2_busy  combinational pending-load queries
//   w_enable/wb_addr/wb_data    registered register-file write port
module wb_arbiter #(
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  q1_addr,
  input  logic [4:0]  q2_addr,
  output logic        q1_busy,
  output logic        q2_busy,
  output logic        w_enable,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  localparam int unsigned AW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    lq_rd_q   [LQ_DEPTH];
  logic [31:0]   lq_data_q [LQ_DEPTH];

  logic [31:0] pend_q, pend_d;
  logic        we_d;
  logic [4:0]  addr_d, addr_q;
  logic [31:0] data_d, data_q;
  logic        we_q;

  logic        push, pop, q_empty;
  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic [31:0] shifted;
  logic [15:0] half;
  logic [31:0] ext_data;

  // Ready depends on registered occupancy only, so no path from alu_valid.
  assign ld_ready  = (count_q != CW'(LQ_DEPTH));
  assign q_empty   = (count_q == '0);
  assign push      = ld_valid && ld_ready;
  assign pop       = !alu_valid && !q_empty;
  assign head_rd   = lq_rd_q[rd_ptr_q];
  assign head_data = lq_data_q[rd_ptr_q];

  // Alignment and extension happen at enqueue so the pop path is a plain mux.
  always_comb begin
    shifted  = ld_data >> {ld_off, 3'b000};
    half     = ld_off[1] ? ld_data[31:16] : ld_data[15:0];
    ext_data = ld_data;
    case (ld_funct3)
      3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext_data = {{16{half[15]}}, half};
      3'b100:  ext_data = {24'b0, shifted[7:0]};
      3'b101:  ext_data = {16'b0, half};
      default: ext_data = ld_data;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Output selection: ALU first, then queue head, else hold address/data.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (alu_valid) begin
      we_d   = (alu_rd != 5'd0);
      addr_d = alu_rd;
      data_d = alu_data;
    end else if (pop) begin
      we_d   = (head_rd != 5'd0);
      addr_d = head_rd;
      data_d = head_data;
    end
  end

  // Clear applied before set so an issue to the register being popped wins.
  always_comb begin
    pend_d = pend_q;
    if (pop && head_rd != 5'd0)        pend_d[head_rd] = 1'b0;
    if (iss_valid && iss_rd != 5'd0)   pend_d[iss_rd]  = 1'b1;
    pend_d[0] = 1'b0;
  end

  assign q1_busy  = pend_q[q1_addr];
  assign q2_busy  = pend_q[q2_addr];
  assign w_enable = we_q;
  assign wb_addr  = addr_q;
  assign wb_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Queue storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd_q[wr_ptr_q]   <= ld_rd;
      lq_data_q[wr_ptr_q] <= ext_data;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int unsigned LQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  q1_addr, q2_addr;
  logic        q1_busy, q2_busy;
  logic        w_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  wb_arbiter #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_funct3(ld_funct3), .ld_off(ld_off),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy),
    .w_enable(w_enable), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model: FIFO of (rd, data), pending set, expected write port.
  ent_t        mq[$];
  bit   [31:0] mpend;
  logic        ewe;
  logic [4:0]  eaddr;
  logic [31:0] edata;
  bit          comb_ok = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [31:0] ext_model(logic [31:0] d, int f3, int off);
    logic [31:0] b, h;
    b = (d >> (8 * off)) % 256;
    h = (off >= 2) ? d / 65536 : d % 65536;
    case (f3)
      0:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4:       return b;
      1:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5:       return h;
      default: return d;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic step();
    bit   push, pop;
    ent_t e;
    #2;
    if (comb_ok) begin
      chk("ld_ready", {31'b0, ld_ready}, {31'b0, mq.size() < LQ_DEPTH});
      chk("q1_busy", {31'b0, q1_busy}, {31'b0, mpend[q1_addr]});
      chk("q2_busy", {31'b0, q2_busy}, {31'b0, mpend[q2_addr]});
    end
    if (rst) begin
      mq.delete();
      mpend = '0;
      ewe = 1'b0; eaddr = '0; edata = '0;
    end else begin
      push = ld_valid && (mq.size() < LQ_DEPTH);
      pop  = !alu_valid && (mq.size() > 0);
      if (alu_valid) begin
        ewe = (alu_rd != 0); eaddr = alu_rd; edata = alu_data;
      end else if (pop) begin
        e = mq.pop_front();
        ewe = (e.rd != 0); eaddr = e.rd; edata = e.data;
        if (e.rd != 0) mpend[e.rd] = 1'b0;
      end else begin
        ewe = 1'b0;
      end
      if (push) begin
        e.rd = ld_rd;
        e.data = ext_model(ld_data, int'(ld_funct3), int'(ld_off));
        mq.push_back(e);
      end
      if (iss_valid && iss_rd != 0) mpend[iss_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
    comb_ok = 1'b1;
    chk("w_enable", {31'b0, w_enable}, {31'b0, ewe});
    chk("wb_addr", {27'b0, wb_addr}, {27'b0, eaddr});
    chk("wb_data", wb_data, edata);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
    alu_rd = '0; alu_data = '0; ld_rd = '0; ld_data = '0; ld_funct3 = '0; ld_off = '0;
    iss_rd = '0;
  endtask

  logic [31:0] ext_word;
  logic [2:0]  ext_f3  [5];
  logic [1:0]  ext_off [5];
  logic [31:0] ext_exp [5];
  int          li;
  bit          acc;
  logic [4:0]  r;

  initial begin
    idle_inputs();
    q1_addr = '0; q2_addr = '0;

    // Reset with a load offered: nothing may be enqueued.
    rst = 1'b1; ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'hDEAD_BEEF;
    step();
    step();
    chk("rst_we", {31'b0, w_enable}, 32'd0);
    rst = 1'b0; ld_valid = 1'b0;
    chk("rst_ready", {31'b0, ld_ready}, 32'd1);
    step();
    step();

    // ALU path.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
    step();
    chk("alu_we", {31'b0, w_enable}, 32'd1);
    chk("alu_data", wb_data, 32'h1234_5678);
    alu_rd = 5'd0; alu_data = 32'hCAFE_0000;
    step();
    chk("alu_rd0_we", {31'b0, w_enable}, 32'd0);
    idle_inputs();
    step();

    // Load extension on one word.
    ext_word = 32'h80FF_7F01;
    ext_f3[0] = 3'b000; ext_off[0] = 2'd2; ext_exp[0] = 32'hFFFF_FFFF;
    ext_f3[1] = 3'b100; ext_off[1] = 2'd3; ext_exp[1] = 32'h0000_0080;
    ext_f3[2] = 3'b001; ext_off[2] = 2'd0; ext_exp[2] = 32'h0000_7F01;
    ext_f3[3] = 3'b001; ext_off[3] = 2'd2; ext_exp[3] = 32'hFFFF_80FF;
    ext_f3[4] = 3'b010; ext_off[4] = 2'd0; ext_exp[4] = 32'h80FF_7F01;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(i + 1); ld_data = ext_word;
      ld_funct3 = ext_f3[i]; ld_off = ext_off[i];
      step();
      ld_valid = 1'b0;
      step();
      chk("ext_data", wb_data, ext_exp[i]);
    end
    step();

    // Priority and backpressure: ALU busy for 5 cycles, 3 loads offered.
    li = 0;
    for (int c = 0; c < 12; c++) begin
      alu_valid = (c < 5); alu_rd = 5'(c + 1); alu_data = $urandom;
      if (li < 3) begin
        ld_valid = 1'b1; ld_rd = 5'(10 + li); ld_data = 32'h100 + 32'(li); ld_funct3 = 3'b010;
      end else begin
        ld_valid = 1'b0;
      end
      acc = ld_valid && (mq.size() < LQ_DEPTH);
      if (c == 3) chk("bp_ready", {31'b0, ld_ready}, 32'd0);
      step();
      if (acc) li++;
    end
    idle_inputs();
    step();

    // Scoreboard set and clear.
    q1_addr = 5'd7; q2_addr = 5'd0;
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0;
    chk("sb_busy7", {31'b0, q1_busy}, 32'd1);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77; ld_funct3 = 3'b010;
    step();
    ld_valid = 1'b0;
    step();
    chk("sb_clear7", {31'b0, q1_busy}, 32'd0);
    iss_valid = 1'b1; iss_rd = 5'd0;
    step();
    iss_valid = 1'b0;
    chk("sb_rd0", {31'b0, q2_busy}, 32'd0);

    // Simultaneous set/clear on r9: set wins.
    q1_addr = 5'd9;
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    step();
    ld_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    chk("setwins9", {31'b0, q1_busy}, 32'd1);
    step();

    // Randomized traffic against the model, with occasional mid-run reset.
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      alu_valid = ($urandom_range(0, 99) < 45);
      alu_rd    = 5'($urandom);
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 99) < 60);
      ld_rd     = 5'($urandom);
      ld_data   = $urandom;
      ld_funct3 = 3'($urandom);
      ld_off    = 2'($urandom);
      r         = 5'($urandom);
      iss_valid = ($urandom_range(0, 99) < 30) && !mpend[r];
      iss_rd    = r;
      q1_addr   = 5'($urandom);
      q2_addr   = r;
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
